// File: rtl/swap_mon_pkg.sv
// Shared types and default widths for the swap-counter monitor.
package swap_mon_pkg;

    typedef enum logic [1:0] {
        NOREF,
        TRACK,
        FAULT
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_COUNT,
        EV_SWAP,
        EV_HOLD,
        EV_ERR
    } event_t;

    localparam int W_DEF        = 4;
    localparam int CW_DEF       = 8;
    localparam int LOCK_CNT_DEF = 3;

endpackage

// File: rtl/swap_counter_monitor_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
// Latency: q reflects inc/clr one cycle after the sampling edge. No backpressure.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {CW{1'b1}})) begin
            q <= q + CW'(1);
        end
    end

endmodule

// File: rtl/swap_counter_monitor.sv
// Decodes up/down swap-counter samples into COUNT/SWAP/HOLD/ERROR events; HOLD enabled by SWAP_MON_HOLD_EN.
// Latency: all outputs registered, valid one cycle after the sampling edge.
// Backpressure: none; samples with in_valid low are ignored.
module swap_counter_monitor
    import swap_mon_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int CW       = CW_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [W-1:0]  up_in,
    input  logic [W-1:0]  down_in,
    input  logic          clr_stats,
    output logic          locked,
    output logic          fault,
    output logic          count_seen,
    output logic          swap_seen,
    output logic          err_seen,
    output logic          hold_seen,
    output logic [CW-1:0] swap_count,
    output logic [CW-1:0] err_count
);

    state_t        state_q, state_d;
    event_t        ev;
    logic [W-1:0]  ref_up, ref_down;
    logic [W-1:0]  up_next, down_next;
    logic [3:0]    lock_q, lock_d;
    logic          is_count, is_swap, live;

    assign up_next   = ref_up + W'(1);
    assign down_next = ref_down - W'(1);
    assign is_count  = (up_in == up_next) && (down_in == down_next);
    assign is_swap   = (up_in == ref_down) && (down_in == ref_up);
    assign live      = in_valid && (state_q != NOREF);

    // COUNT outranks SWAP when ref_down == ref_up + 1 makes both match.
    always_comb begin
        ev = EV_ERR;
        if (is_count) begin
            ev = EV_COUNT;
        end else if (is_swap) begin
            ev = EV_SWAP;
`ifdef SWAP_MON_HOLD_EN
        end else if ((up_in == ref_up) && (down_in == ref_down)) begin
            ev = EV_HOLD;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        if (in_valid) begin
            case (state_q)
                NOREF: begin
                    state_d = TRACK;
                    lock_d  = '0;
                end
                TRACK: begin
                    if (ev == EV_ERR) begin
                        state_d = FAULT;
                        lock_d  = '0;
                    end
                end
                FAULT: begin
                    if (ev == EV_COUNT || ev == EV_SWAP) begin
                        if ((lock_q + 4'd1) >= 4'(LOCK_CNT)) begin
                            state_d = TRACK;
                            lock_d  = '0;
                        end else begin
                            lock_d = lock_q + 4'd1;
                        end
                    end else if (ev == EV_ERR) begin
                        lock_d = '0;
                    end
                end
                default: begin
                    state_d = NOREF;
                    lock_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= NOREF;
            lock_q     <= '0;
            ref_up     <= '0;
            ref_down   <= '0;
            count_seen <= 1'b0;
            swap_seen  <= 1'b0;
            err_seen   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            count_seen <= live && (ev == EV_COUNT);
            swap_seen  <= live && (ev == EV_SWAP);
            err_seen   <= live && (ev == EV_ERR);
            // Reference follows every valid sample, even an illegal one.
            if (in_valid) begin
                ref_up   <= up_in;
                ref_down <= down_in;
            end
        end
    end

`ifdef SWAP_MON_HOLD_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_seen <= 1'b0;
        end else begin
            hold_seen <= live && (ev == EV_HOLD);
        end
    end
`else
    assign hold_seen = 1'b0;
`endif

    assign locked = (state_q == TRACK);
    assign fault  = (state_q == FAULT);

    sat_counter #(.CW(CW)) u_swap_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (live && (ev == EV_SWAP)),
        .clr     (clr_stats),
        .q       (swap_count)
    );

    sat_counter #(.CW(CW)) u_err_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (live && (ev == EV_ERR)),
        .clr     (clr_stats),
        .q       (err_count)
    );

endmodule

// File: tb/tb_swap_counter_monitor.sv
// Scoreboard bench for swap_counter_monitor: a behavioural model pushes expected outputs per cycle.
module tb_swap_counter_monitor;

    localparam int W        = 4;
    localparam int CW       = 8;
    localparam int LOCK_CNT = 3;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  up_in = '0;
    logic [W-1:0]  down_in = '0;
    logic          clr_stats = 1'b0;
    logic          locked, fault, count_seen, swap_seen, err_seen, hold_seen;
    logic [CW-1:0] swap_count, err_count;

    swap_counter_monitor #(.W(W), .CW(CW), .LOCK_CNT(LOCK_CNT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .up_in      (up_in),
        .down_in    (down_in),
        .clr_stats  (clr_stats),
        .locked     (locked),
        .fault      (fault),
        .count_seen (count_seen),
        .swap_seen  (swap_seen),
        .err_seen   (err_seen),
        .hold_seen  (hold_seen),
        .swap_count (swap_count),
        .err_count  (err_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Packed output word: {locked, fault, count, swap, err, hold, swap_count, err_count}
    typedef struct {
        logic [31:0] val;
        string       tag;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] observe();
        return {10'd0, locked, fault, count_seen, swap_seen, err_seen, hold_seen, swap_count, err_count};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    int         m_state = 0;   // 0 NOREF, 1 TRACK, 2 FAULT
    logic [3:0] m_ru = '0, m_rd = '0;
    int         m_lock = 0;
    int         m_swaps = 0, m_errs = 0;

    task automatic model_reset();
        m_state = 0; m_ru = '0; m_rd = '0; m_lock = 0; m_swaps = 0; m_errs = 0;
    endtask

    task automatic model_step(input bit v, input logic [3:0] u, input logic [3:0] d,
                              input bit c, input string tag);
        bit pc, ps, pe, ph;
        logic [3:0] up1, dn1;
        exp_t e;
        pc = 0; ps = 0; pe = 0; ph = 0;
        up1 = m_ru + 4'd1;
        dn1 = m_rd - 4'd1;
        if (v) begin
            if (m_state == 0) begin
                m_state = 1;
                m_lock  = 0;
            end else begin
                if (u == up1 && d == dn1)              pc = 1;
                else if (u == m_rd && d == m_ru)       ps = 1;
`ifdef SWAP_MON_HOLD_EN
                else if (u == m_ru && d == m_rd)       ph = 1;
`endif
                else                                   pe = 1;
                if (pe) begin
                    if (!c && m_errs < 255) m_errs++;
                    m_state = 2;
                    m_lock  = 0;
                end else if (pc || ps) begin
                    if (ps && !c && m_swaps < 255) m_swaps++;
                    if (m_state == 2) begin
                        m_lock++;
                        if (m_lock == LOCK_CNT) begin
                            m_state = 1;
                            m_lock  = 0;
                        end
                    end
                end
            end
            m_ru = u;
            m_rd = d;
        end
        if (c) begin
            m_swaps = 0;
            m_errs  = 0;
        end
        e.tag = tag;
        e.val = {10'd0, (m_state == 1), (m_state == 2), pc, ps, pe, ph, 8'(m_swaps), 8'(m_errs)};
        sb.push_back(e);
    endtask

    task automatic drive(input bit v, input logic [3:0] u, input logic [3:0] d,
                         input bit c, input string tag);
        @(negedge clock);
        in_valid  = v;
        up_in     = u;
        down_in   = d;
        clr_stats = c;
        model_step(v, u, d, c, tag);
    endtask

    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, observe(), e.val);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        check("reset_state", observe(), 32'd0);
        reset_n = 1'b1;

        drive(1, 4'd0,  4'd15, 0, "first_sample");
        drive(1, 4'd1,  4'd14, 0, "count1");
        drive(1, 4'd2,  4'd13, 0, "count2");
        drive(1, 4'd13, 4'd2,  0, "swap1");
        drive(0, 4'd9,  4'd9,  0, "idle_ignored");
        drive(1, 4'd2,  4'd13, 0, "swap2");
        drive(1, 4'd3,  4'd12, 0, "count3");
        drive(1, 4'd5,  4'd5,  0, "error_enter_fault");
        drive(1, 4'd6,  4'd4,  0, "fault_count_lock1");
        drive(1, 4'd4,  4'd6,  0, "fault_swap_lock2");
        drive(1, 4'd5,  4'd5,  0, "fault_count_relock");
        drive(1, 4'd15, 4'd0,  0, "set_ref_15_0");
        drive(1, 4'd0,  4'd15, 0, "wrap_count");
        drive(1, 4'd3,  4'd4,  0, "set_ref_3_4");
        drive(1, 4'd4,  4'd3,  0, "count_over_swap");
        drive(1, 4'd6,  4'd2,  0, "error_in_fault");
        drive(1, 4'd2,  4'd6,  0, "fault_swap_after_err");

        drive(1, 4'd1, 4'd9, 0, "sat_setup");
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) drive(1, 4'd9, 4'd1, 0, "sat_swap");
            else            drive(1, 4'd1, 4'd9, 0, "sat_swap");
        end
        drive(1, 4'd9, 4'd1, 1, "clr_with_swap");
        drive(1, 4'd1, 4'd9, 0, "swap_after_clr");
        drive(0, 4'd0, 4'd0, 1, "clr_idle");

        drive(1, 4'd7, 4'd8, 0, "set_ref_7_8");
        drive(1, 4'd7, 4'd8, 0, "hold_sample");
        drive(1, 4'd8, 4'd7, 0, "after_hold");

        @(negedge clock);
        in_valid = 1'b0;
        clr_stats = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("async_reset", observe(), 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        drive(1, 4'd2, 4'd3, 0, "resync_first");
        drive(1, 4'd3, 4'd2, 0, "resync_count");
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
